present_cipher_core: RTL



---
 rtl/present_pkg.sv | 94 +++++++++
 rtl/present_key_schedule.sv | 53 +++++
 rtl/present_cipher_core.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT primitives: S-box layers, bit permutation, FSM state codes and key widths.
// Inverse primitives exist only when PRESENT_DECRYPT_EN is defined.
package present_pkg;

   localparam int unsigned BLK_W    = 64;
   localparam int unsigned RC_W     = 5;
   localparam int unsigned KEY_W80  = 80;
   localparam int unsigned KEY_W128 = 128;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_KEYGEN = 2'd1;
   localparam logic [1:0] S_RUN    = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0:    y = 4'hC;
         4'h1:    y = 4'h5;
         4'h2:    y = 4'h6;
         4'h3:    y = 4'hB;
         4'h4:    y = 4'h9;
         4'h5:    y = 4'h0;
         4'h6:    y = 4'hA;
         4'h7:    y = 4'hD;
         4'h8:    y = 4'h3;
         4'h9:    y = 4'hE;
         4'hA:    y = 4'hF;
         4'hB:    y = 4'h8;
         4'hC:    y = 4'h4;
         4'hD:    y = 4'h7;
         4'hE:    y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
      return y;
   endfunction

   // Bit i moves to position 16*i mod 63; bit 63 stays put.
   function automatic logic [BLK_W-1:0] player(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 63; i++) y[6'((i * 16) % 63)] = x[i];
      y[63] = x[63];
      return y;
   endfunction

`ifdef PRESENT_DECRYPT_EN
   function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0:    y = 4'h5;
         4'h1:    y = 4'hE;
         4'h2:    y = 4'hF;
         4'h3:    y = 4'h8;
         4'h4:    y = 4'hC;
         4'h5:    y = 4'h1;
         4'h6:    y = 4'h2;
         4'h7:    y = 4'hD;
         4'h8:    y = 4'hB;
         4'h9:    y = 4'h4;
         4'hA:    y = 4'h6;
         4'hB:    y = 4'h3;
         4'hC:    y = 4'h0;
         4'hD:    y = 4'h7;
         4'hE:    y = 4'h9;
         default: y = 4'hA;
      endcase
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] sbox_layer_inv(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4_inv(x[4*i +: 4]);
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] player_inv(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      y = '0;
      for (int i = 0; i < 63; i++) y[i] = x[6'((i * 16) % 63)];
      y[63] = x[63];
      return y;
   endfunction
`endif

endpackage

// File: rtl/present_key_schedule.sv
// Combinational PRESENT key-register update (80/128-bit) plus round-key extraction.
// With PRESENT_DECRYPT_EN a direction input selects the inverse update.
module present_key_schedule
   import present_pkg::*;
#(
   parameter int unsigned KEY_WIDTH = 128
)
(
   input  logic [KEY_WIDTH-1:0] keyreg,
   input  logic [RC_W-1:0]      rc,
`ifdef PRESENT_DECRYPT_EN
   input  logic                 direction,
`endif
   output logic [KEY_WIDTH-1:0] key_nx_c,
   output logic [BLK_W-1:0]     rkey_c
);

   localparam int unsigned KW    = KEY_WIDTH;
   localparam int unsigned RC_LO = (KEY_WIDTH == KEY_W80) ? 15 : 62;

   if (!(KEY_WIDTH == KEY_W80 || KEY_WIDTH == KEY_W128)) begin : g_bad_width
      $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
   end

   logic [KW-1:0] fwd;

   // Forward step: rotate left 61, S-box the top nibble(s), fold in the round counter.
   always_comb begin
      fwd = {keyreg[KW-62:0], keyreg[KW-1:KW-61]};
      fwd[KW-1 -: 4] = sbox4(fwd[KW-1 -: 4]);
      if (KW == KEY_W128) fwd[KW-5 -: 4] = sbox4(fwd[KW-5 -: 4]);
      fwd[RC_LO +: RC_W] = fwd[RC_LO +: RC_W] ^ rc;
   end

`ifdef PRESENT_DECRYPT_EN
   logic [KW-1:0] inv_pre;

   // Inverse step undoes the forward step in reverse order, ending with rotate right 61.
   always_comb begin
      inv_pre = keyreg;
      inv_pre[RC_LO +: RC_W] = inv_pre[RC_LO +: RC_W] ^ rc;
      inv_pre[KW-1 -: 4] = sbox4_inv(inv_pre[KW-1 -: 4]);
      if (KW == KEY_W128) inv_pre[KW-5 -: 4] = sbox4_inv(inv_pre[KW-5 -: 4]);
   end

   assign key_nx_c = direction ? {inv_pre[60:0], inv_pre[KW-1:61]} : fwd;
`else
   assign key_nx_c = fwd;
`endif

   assign rkey_c = keyreg[KW-1 -: BLK_W];

endmodule

// File: rtl/present_cipher_core.sv
// Iterative round-per-cycle PRESENT cipher with valid/ready handshakes, one block in flight.
// Optional decryption (mode port, KEYGEN state) is built when PRESENT_DECRYPT_EN is defined.
module present_cipher_core
   import present_pkg::*;
#(
   parameter int unsigned KEY_WIDTH = 128,
   parameter int unsigned ROUNDS    = 31
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BLK_W-1:0]     plaintext,
   input  logic [KEY_WIDTH-1:0] key,
`ifdef PRESENT_DECRYPT_EN
   input  logic                 mode,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BLK_W-1:0]     ciphertext,
   output logic                 busy
);

   localparam int unsigned       KW      = KEY_WIDTH;
   localparam logic [RC_W-1:0]   RC_LAST = RC_W'(ROUNDS);

   if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_cipher_core: ROUNDS must be in 1..31");
   end

   logic [1:0]       st_q, st_nx;
   logic [RC_W-1:0]  rc_q, rc_nx;
   logic [BLK_W-1:0] blk_q, blk_nx;
   logic [KW-1:0]    key_q, key_nx;
   logic [KW-1:0]    ks_key_c;
   logic [BLK_W-1:0] ks_rkey_c;
   logic [BLK_W-1:0] enc_rnd_c;
   logic [BLK_W-1:0] last_rk_c;

`ifdef PRESENT_DECRYPT_EN
   logic             dec_q, dec_nx;
   logic             ks_dir_c;
   logic [BLK_W-1:0] dec_rnd_c;

   assign ks_dir_c  = (st_q == S_RUN) && dec_q;
   assign dec_rnd_c = sbox_layer_inv(player_inv(blk_q ^ ks_rkey_c));
`endif

   present_key_schedule #(
      .KEY_WIDTH (KEY_WIDTH)
   ) u_ks (
      .keyreg    (key_q),
      .rc        (rc_q),
`ifdef PRESENT_DECRYPT_EN
      .direction (ks_dir_c),
`endif
      .key_nx_c  (ks_key_c),
      .rkey_c    (ks_rkey_c)
   );

   // Round datapath; last_rk_c is the key the next step produces (whitening key on the final round).
   assign enc_rnd_c = player(sbox_layer(blk_q ^ ks_rkey_c));
   assign last_rk_c = ks_key_c[KW-1 -: BLK_W];

   always_comb begin
      st_nx  = st_q;
      rc_nx  = rc_q;
      blk_nx = blk_q;
      key_nx = key_q;
`ifdef PRESENT_DECRYPT_EN
      dec_nx = dec_q;
`endif
      case (st_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               blk_nx = plaintext;
               key_nx = key;
               rc_nx  = RC_W'(1);
`ifdef PRESENT_DECRYPT_EN
               dec_nx = mode;
               st_nx  = mode ? S_KEYGEN : S_RUN;
`else
               st_nx  = S_RUN;
`endif
            end
         end
`ifdef PRESENT_DECRYPT_EN
         // Walk the forward schedule to K(ROUNDS+1); rc stays at ROUNDS for the inverse rounds.
         S_KEYGEN: begin
            key_nx = ks_key_c;
            if (rc_q == RC_LAST) st_nx = S_RUN;
            else                 rc_nx = rc_q + RC_W'(1);
         end
`endif
         S_RUN: begin
            key_nx = ks_key_c;
`ifdef PRESENT_DECRYPT_EN
            if (dec_q) begin
               blk_nx = dec_rnd_c;
               if (rc_q == RC_W'(1)) begin
                  blk_nx = dec_rnd_c ^ last_rk_c;
                  st_nx  = S_DONE;
               end else begin
                  rc_nx = rc_q - RC_W'(1);
               end
            end else
`endif
            begin
               blk_nx = enc_rnd_c;
               if (rc_q == RC_LAST) begin
                  blk_nx = enc_rnd_c ^ last_rk_c;
                  st_nx  = S_DONE;
               end else begin
                  rc_nx = rc_q + RC_W'(1);
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               st_nx = S_IDLE;
               rc_nx = '0;
            end
         end
         default: st_nx = S_IDLE;
      endcase
   end

   // State and outputs registered together; outputs derive from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= S_IDLE;
         rc_q       <= '0;
         blk_q      <= '0;
         key_q      <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         ciphertext <= '0;
`ifdef PRESENT_DECRYPT_EN
         dec_q      <= 1'b0;
`endif
      end else begin
         st_q       <= st_nx;
         rc_q       <= rc_nx;
         blk_q      <= blk_nx;
         key_q      <= key_nx;
         in_ready   <= (st_nx == S_IDLE);
         out_valid  <= (st_nx == S_DONE);
         busy       <= (st_nx != S_IDLE);
         ciphertext <= (st_nx == S_DONE) ? blk_nx : '0;
`ifdef PRESENT_DECRYPT_EN
         dec_q      <= dec_nx;
`endif
      end
   end

endmodule
